kernel_frame_scheduler: RTL
===========================

Name: kernel_frame_scheduler

Overview:
Sequences the convolution datapath at frame granularity. It tracks the pixel position of the loader's valid stream (row/col, start/end of frame) and owns the conv_kernel coefficient set. Host/debug logic writes coefficients into a shadow bank; a commit request copies the shadow bank into the active kernel only at a frame boundary, so no frame is ever filtered with mixed coefficients. Sits between image_loader valid and the conv_kernel kernel input; RGB_Process row/col also come from here.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, lines per frame
SIZE, 11, kernel edge length (SIZE*SIZE taps)
KERNEL_WIDTH, 9, signed coefficient width
ADDR_W, 7, tap address width; must satisfy 2^ADDR_W >= SIZE*SIZE

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
valid_i  in  1  pixel accepted this cycle (from image_loader valid)
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  ADDR_W  tap index = r*SIZE + c
cfg_wdata  in  KERNEL_WIDTH  signed coefficient
cfg_commit  in  1  request shadow->active transfer
cfg_ready  out  1  high when writes/commits are accepted
kernel_flat  out  SIZE*SIZE*KERNEL_WIDTH  active coefficients, tap i at bits [i*KW +: KW]
kernel_update  out  1  one-cycle pulse, first cycle new kernel_flat is valid
row  out  13  line of the pixel presented with valid_i
col  out  13  column of the pixel presented with valid_i
sof  out  1  valid_i && row==0 && col==0
eof  out  1  valid_i && row==HEIGHT-1 && col==WIDTH-1
frame_count  out  16  completed frames, wraps at 2^16
cfg_err  out  1  sticky: out-of-range address or write/commit while not ready

Behaviour:
- Reset (async, any time): row=col=0, frame_count=0, shadow and active banks all zero, kernel_update=0, cfg_err=0, state=RUN, cfg_ready=1; a pending commit is dropped.
- Position counter: on valid_i, col increments; at col==WIDTH-1, col->0 and row increments; at row==HEIGHT-1 too, row->0 and frame_count+1. No change without valid_i. sof/eof are combinational decodes of registered row/col and valid_i.
- Idle boundary: idle_bnd = (row==0 && col==0 && !valid_i).
- States: RUN, PENDING.
  RUN: cfg_ready=1. cfg_we with cfg_addr < SIZE*SIZE writes the shadow tap; cfg_addr >= SIZE*SIZE is ignored and sets cfg_err. On cfg_commit: if idle_bnd or eof this cycle, copy shadow->active at this edge, stay RUN; otherwise go PENDING.
  PENDING: cfg_ready=0. cfg_we/cfg_commit ignored and set cfg_err. On eof: copy shadow->active at this edge, go RUN. Reset is the only other exit.
- A cfg_we and cfg_commit in the same RUN cycle: the write lands in the shadow first and is included in the transfer.
- kernel_update is registered: high exactly in the cycle after the copy edge, when kernel_flat first shows the new values; low otherwise.
- Latency: commit during a frame -> new kernel visible the cycle after the eof pixel is accepted, i.e. before the next sof. Commit at idle_bnd -> visible next cycle.
- kernel_flat is driven straight from active registers, never from shadow; active changes only on a copy edge or reset.
- cfg_err clears only on reset.

Decomposition:
- Shared package: KERNEL taps count (SIZE*SIZE), ADDR_W check, state enum {RUN, PENDING}, default WIDTH/HEIGHT constants shared with image_loader/image_dumper.
- One sub-module: pixel_position_counter (row/col/frame_count, sof/eof decode), reusable by RGB_Process wrappers and benches.

Test Plan:
- Counter wrap (WIDTH=4, HEIGHT=3): 12 valid pulses with random gaps -> sof on pixel 0 only, eof on pixel 11 only, row/col return to 0/0, frame_count=1; 24 pulses -> frame_count=2.
- Idle commit: after reset write tap 60=160 and tap 0=-5, commit with valid_i low -> kernel_update the next cycle, tap60=160, tap0=-5 (0x1FB), all other taps 0, cfg_ready stays 1.
- Mid-frame commit: at pixel 5 write tap 60=100, commit -> cfg_ready=0; kernel_flat unchanged through pixel 11; kernel_update one cycle after eof, tap60=100; cfg_ready=1 from then on.
- Commit coincident with eof, with cfg_we tap 1=7 same cycle -> no PENDING, tap1=7 active the next cycle.
- Errors: write addr 121 in RUN -> shadow unchanged, cfg_err=1; write during PENDING -> ignored, cfg_err stays 1 until reset.
- Reset mid-PENDING at pixel 7 -> row/col/frame_count 0, kernel all zero, no kernel_update at the following eof, cfg_ready=1.

Source files
------------

// File: rtl/kernel_frame_scheduler_pkg.sv
// Shared constants, scheduler state encoding and tap-count helpers for the conv kernel path.
// Frame geometry defaults match image_loader/image_dumper.
package kernel_frame_scheduler_pkg;
    localparam int DEF_WIDTH        = 640;
    localparam int DEF_HEIGHT       = 480;
    localparam int DEF_SIZE         = 11;
    localparam int DEF_KERNEL_WIDTH = 9;
    localparam int DEF_ADDR_W       = 7;
    localparam int POS_W            = 13;
    localparam int FRAME_W          = 16;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } sched_state_t;

    function automatic int kernel_taps(input int size);
        return size * size;
    endfunction

    function automatic bit addr_w_ok(input int addr_w, input int size);
        return (1 << addr_w) >= size * size;
    endfunction
endpackage

// File: rtl/kernel_frame_scheduler_position.sv
// Pixel position tracker: row/col/frame_count advance on each accepted pixel.
// sof/eof are same-cycle decodes of the registered position and valid_i; no backpressure.
module pixel_position_counter
    import kernel_frame_scheduler_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    output logic [POS_W-1:0]   row,
    output logic [POS_W-1:0]   col,
    output logic               sof,
    output logic               eof,
    output logic [FRAME_W-1:0] frame_count
);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(HEIGHT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            frame_count <= '0;
        end else if (valid_i) begin
            if (col == LAST_COL) begin
                col <= '0;
                if (row == LAST_ROW) begin
                    row         <= '0;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign sof = valid_i && (row == '0) && (col == '0);
    assign eof = valid_i && (row == LAST_ROW) && (col == LAST_COL);
endmodule

// File: rtl/kernel_frame_scheduler.sv
// Owns the conv kernel coefficients: shadow bank written by host, copied to active only at a frame edge.
// Copy visible one cycle after commit at idle boundary or after the eof pixel; cfg_ready drops while a copy is pending.
module kernel_frame_scheduler
    import kernel_frame_scheduler_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int SIZE         = DEF_SIZE,
    parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_i,
    input  logic                                  cfg_we,
    input  logic [ADDR_W-1:0]                     cfg_addr,
    input  logic signed [KERNEL_WIDTH-1:0]        cfg_wdata,
    input  logic                                  cfg_commit,
    output logic                                  cfg_ready,
    output logic [SIZE*SIZE*KERNEL_WIDTH-1:0]     kernel_flat,
    output logic                                  kernel_update,
    output logic [POS_W-1:0]                      row,
    output logic [POS_W-1:0]                      col,
    output logic                                  sof,
    output logic                                  eof,
    output logic [FRAME_W-1:0]                    frame_count,
    output logic                                  cfg_err
);
    localparam int          TAPS   = kernel_taps(SIZE);
    localparam logic [31:0] TAPS_U = 32'(TAPS);

    if (!addr_w_ok(ADDR_W, SIZE)) begin : g_addr_w_check
        $error("ADDR_W too narrow to address SIZE*SIZE taps");
    end

    sched_state_t            state;
    logic [KERNEL_WIDTH-1:0] shadow [TAPS];
    logic [KERNEL_WIDTH-1:0] active [TAPS];
    logic                    idle_bnd, addr_ok, wr_hit, copy, err_ev;

    pixel_position_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .row        (row),
        .col        (col),
        .sof        (sof),
        .eof        (eof),
        .frame_count(frame_count)
    );

    assign idle_bnd = (row == '0) && (col == '0) && !valid_i;
    assign addr_ok  = 32'(cfg_addr) < TAPS_U;
    assign wr_hit   = (state == RUN) && cfg_we && addr_ok;
    assign copy     = ((state == RUN) && cfg_commit && (idle_bnd || eof)) ||
                      ((state == PENDING) && eof);
    assign err_ev   = ((state == RUN) && cfg_we && !addr_ok) ||
                      ((state == PENDING) && (cfg_we || cfg_commit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            cfg_ready     <= 1'b1;
            kernel_update <= 1'b0;
            cfg_err       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            kernel_update <= copy;
            if (err_ev)
                cfg_err <= 1'b1;
            if (wr_hit)
                shadow[cfg_addr] <= cfg_wdata;
            // A write in the commit cycle is forwarded so it joins the transfer.
            if (copy) begin
                for (int i = 0; i < TAPS; i++)
                    active[i] <= (wr_hit && cfg_addr == ADDR_W'(i)) ? cfg_wdata : shadow[i];
            end
            case (state)
                RUN: if (cfg_commit && !copy) begin
                    state     <= PENDING;
                    cfg_ready <= 1'b0;
                end
                PENDING: if (eof) begin
                    state     <= RUN;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= RUN;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_flat
        assign kernel_flat[g*KERNEL_WIDTH +: KERNEL_WIDTH] = active[g];
    end
endmodule
